sprite_pixel_fetch: RTL

Responder end of the sprite-address interface driven by the player animation blocks. Accepts one pixel request per clock: a sprite ROM address plus an on-sprite flag. It issues the ROM read, waits out the fixed ROM latency, and maps the returned palette index to 24-bit RGB. It returns a pixel that is aligned, valid-tagged and flagged transparent or opaque to the VGA colour mapper.

---
 rtl/sprite_pixel_fetch.sv | 137 +++++++++++++
 1 files changed

// File: rtl/sprite_pixel_fetch.sv
// sprite_pixel_fetch: turns animation-block pixel requests into palette-mapped RGB.
// A request issues a sprite ROM read, its tag rides a shift pipe while the ROM
// answers, and the returned palette index is mapped to RGB through a 2^IDX_W
// entry palette. The palette is cleared by an INIT sweep after every reset.
// Optional build macro: SPRITE_FETCH_PERF_EN adds frame_start / opaque_count.
module sprite_pixel_fetch #(
  parameter int          ADDR_W          = 21,
  parameter int          IDX_W           = 4,
  parameter int          ROM_LATENCY     = 2,
  parameter int unsigned TRANSPARENT_IDX = 0
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              req_valid,
  input  logic              req_on,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              rom_rd,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [IDX_W-1:0]  rom_data,
  input  logic              pal_wr_en,
  input  logic [IDX_W-1:0]  pal_wr_idx,
  input  logic [23:0]       pal_wr_rgb,
  output logic              busy,
  output logic              pix_valid,
  output logic              pix_opaque,
  output logic [23:0]       pix_rgb
`ifdef SPRITE_FETCH_PERF_EN
  ,
  input  logic              frame_start,
  output logic [15:0]       opaque_count
`endif
);

  localparam int PAL_N = 1 << IDX_W;

  typedef enum logic {INIT, RUN} state_t;

  state_t             stateQ, stateD;
  logic [IDX_W-1:0]   initCnt;
  logic [23:0]        palette [PAL_N];
  // Index 0 lines up with rom_rd; index ROM_LATENCY lines up with rom_data.
  logic [ROM_LATENCY:0] tagValid;
  logic [ROM_LATENCY:0] tagOn;
  logic               accept;
  logic               exitValid;
  logic               exitOn;
  logic               opaqueD;
  logic               palWrite;
  logic [23:0]        palRead;

  assign accept    = req_valid && (stateQ == RUN);
  assign exitValid = tagValid[ROM_LATENCY];
  assign exitOn    = tagOn[ROM_LATENCY];
  assign palWrite  = pal_wr_en && (stateQ == RUN);

  // State register and the palette-clear sweep counter.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      stateQ  <= INIT;
      initCnt <= '0;
    end else begin
      stateQ <= stateD;
      if (stateQ == INIT) initCnt <= initCnt + 1'b1;
    end
  end

  // Next state: leave INIT once the last palette entry is cleared; RUN is sticky.
  always_comb begin
    stateD = stateQ;
    busy   = 1'b0;
    case (stateQ)
      INIT: begin
        busy = 1'b1;
        if (&initCnt) stateD = RUN;
      end
      RUN: stateD = RUN;
      default: stateD = INIT;
    endcase
  end

  // Palette storage: cleared entry by entry in INIT, host-writable in RUN.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      if (stateQ == INIT) palette[initCnt] <= '0;
      else if (pal_wr_en) palette[pal_wr_idx] <= pal_wr_rgb;
    end
  end

  // Request stage: launch the ROM read and push the tag into the latency pipe.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      rom_rd   <= 1'b0;
      rom_addr <= '0;
      tagValid <= '0;
      tagOn    <= '0;
    end else begin
      rom_rd <= accept && req_on;
      if (accept && req_on) rom_addr <= req_addr;
      tagValid <= {tagValid[ROM_LATENCY-1:0], accept};
      tagOn    <= {tagOn[ROM_LATENCY-1:0], accept && req_on};
    end
  end

  // Palette lookup with a bypass so a same-edge write is seen by the lookup.
  always_comb begin
    palRead = palette[rom_data];
    if (palWrite && (pal_wr_idx == rom_data)) palRead = pal_wr_rgb;
    opaqueD = exitValid && exitOn && (rom_data != IDX_W'(TRANSPARENT_IDX));
  end

  // Result stage: register the pixel as the tag leaves the pipe.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      pix_valid  <= 1'b0;
      pix_opaque <= 1'b0;
      pix_rgb    <= '0;
    end else begin
      pix_valid  <= exitValid;
      pix_opaque <= opaqueD;
      pix_rgb    <= opaqueD ? palRead : 24'h0;
    end
  end

`ifdef SPRITE_FETCH_PERF_EN
  // Saturating count of drawn pixels; a frame start clears it first.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      opaque_count <= '0;
    end else if (frame_start) begin
      opaque_count <= '0;
    end else if (pix_valid && pix_opaque && (opaque_count != 16'hFFFF)) begin
      opaque_count <= opaque_count + 16'd1;
    end
  end
`endif

endmodule
